sample_delay_ctrl: RTL and testbench
====================================

// Module: sample_delay_ctrl
// PURPOSE
//  Initiator side of the single-port RAM interface (wEn/addr/dataIn/dataOut, RAM acts on negedge clk).
//  Uses the RAM as a circular audio delay line for the karaoke echo path: per accepted sample, reads
//  the sample written 'delay' samples earlier, writes the new sample, returns the delayed one.
//  Sits between the sample source and the echo mixer; owns the RAM port exclusively.
// PARAMETERS
//  DATA_WIDTH     32    sample / RAM word width
//  ADDRESS_WIDTH  12    RAM address width
//  DEPTH          4096  RAM words; must equal 2**ADDRESS_WIDTH (pointer wrap is modulo DEPTH)
// PORTS
//  clk          in   1              single clock; RAM samples ram_* on negedge, this block on posedge
//  rst_n        in   1              asynchronous, active-low reset
//  delay        in   ADDRESS_WIDTH  delay in samples; latched when a sample is accepted
//  in_valid     in   1              input sample valid
//  in_ready     out  1              block can accept a sample
//  in_data      in   DATA_WIDTH     input sample
//  out_valid    out  1              delayed sample valid
//  out_ready    in   1              consumer accepts delayed sample
//  out_data     out  DATA_WIDTH     delayed sample
//  ram_wEn      out  1              RAM write enable
//  ram_addr     out  ADDRESS_WIDTH  RAM address
//  ram_dataIn   out  DATA_WIDTH     RAM write data
//  ram_dataOut  in   DATA_WIDTH     RAM read data (updated at negedge when ram_wEn=0)
// BEHAVIOUR
//  - Reset (async): state=CLEAR, clr_cnt=0, wptr=0, out_valid=0, out_data=0, in_ready=0.
//    During reset ram_wEn=1, ram_addr=0, ram_dataIn=0 (zero write to word 0 is harmless).
//  - ram_* decoded from state/pointer registers only; no combinational path from any input;
//    stable from posedge to next posedge, so valid at the intervening negedge.
//  - FSM:
//    CLEAR: ram_wEn=1, ram_addr=clr_cnt, ram_dataIn=0; clr_cnt++ each cycle; after addr DEPTH-1
//           -> IDLE. Exactly DEPTH cycles; in_ready=0 throughout.
//    IDLE:  in_ready=1, ram_wEn=0. in_valid&in_ready -> latch in_data into smp, delay into dly -> READ.
//    READ:  ram_wEn=0, ram_addr=(wptr-dly) mod DEPTH. -> WRITE.
//    WRITE: capture out_data = (dly==0) ? smp : ram_dataOut (RAM output from READ negedge);
//           ram_wEn=1, ram_addr=wptr, ram_dataIn=smp; wptr<=wptr+1 (wraps DEPTH-1 -> 0). -> OUT.
//    OUT:   out_valid=1, out_data held; out_valid&out_ready -> out_valid=0 -> IDLE.
//  - Throughput: one sample per 4 cycles with out_ready held high; latency in-accept to
//    out_valid = 3 cycles.
//  - Backpressure: in OUT with out_ready=0, out_valid/out_data hold, in_ready=0, ram_wEn=0.
//  - in_ready=1 only in IDLE; in_valid outside IDLE ignored (source must hold it).
//  - delay changes mid-sample have no effect until next accept; delay=0 is pure bypass
//    (sample still written to RAM).
//  - History is zero after every reset (CLEAR), so first 'delay' outputs are 0.
//  - Reset mid-operation: in-flight sample dropped, out_valid drops asynchronously, CLEAR reruns.
// STRUCTURE
//  - Shared package: state encoding (CLEAR, IDLE, READ, WRITE, OUT) as localparams/typedef;
//    RAM geometry defaults (DATA_WIDTH, ADDRESS_WIDTH, DEPTH) shared with the RAM.
//  - Single module; no sub-module needed (clr_cnt and wptr may share one ADDRESS_WIDTH counter
//    since they are never live together).
// TESTING (bench uses ADDRESS_WIDTH=4, DEPTH=16, real RAM model on the ram_* port)
//  1 Release rst_n -> in_ready rises exactly 16 cycles later; all 16 RAM words read back 0.
//  2 delay=3, push 1..8, out_ready=1 -> out_data 0,0,0,1,2,3,4,5; 4 cycles per sample.
//  3 delay=0, push 5,6,7 -> out_data 5,6,7; RAM words 0..2 hold 5,6,7.
//  4 delay=15, push k=1..40 -> out k-15 for k>=16, 0 for k<=15; wptr wraps twice cleanly.
//  5 Hold out_ready=0 for 10 cycles in OUT -> out_valid=1, out_data stable, in_ready=0,
//    ram_wEn=0 whole time; release -> next sample accepted.
//  6 Assert rst_n low in WRITE -> out_valid=0 immediately; after CLEAR, delay=2 outputs 0,0,first.

Source files
------------

// File: rtl/sample_delay_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sample_delay_ctrl_pkg
// Brief    : FSM encoding and RAM geometry shared by the echo delay line.
// Revision : 1.0
// ============================================================================
package sample_delay_ctrl_pkg;

    localparam int SDC_DATA_WIDTH    = 32;
    localparam int SDC_ADDRESS_WIDTH = 12;
    localparam int SDC_DEPTH         = 4096;

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_IDLE  = 3'd1,
        ST_READ  = 3'd2,
        ST_WRITE = 3'd3,
        ST_OUT   = 3'd4
    } sdc_state_t;

endpackage
`default_nettype wire

// File: rtl/sample_delay_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : sample_delay_ctrl_if
// Brief    : Sample stream in/out plus single-port RAM port of the delay line.
// Revision : 1.0
// ============================================================================
interface sample_delay_ctrl_if
    import sample_delay_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = SDC_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = SDC_ADDRESS_WIDTH
) ();

    logic [ADDRESS_WIDTH-1:0] delay;
    logic                     in_valid;
    logic                     in_ready;
    logic [DATA_WIDTH-1:0]    in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_WIDTH-1:0]    out_data;
    logic                     ram_wEn;
    logic [ADDRESS_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0]    ram_dataIn;
    logic [DATA_WIDTH-1:0]    ram_dataOut;

    // Controller side
    modport master (
        input  delay, in_valid, in_data, out_ready, ram_dataOut,
        output in_ready, out_valid, out_data, ram_wEn, ram_addr, ram_dataIn
    );

    // Environment side: sample source, echo mixer and RAM
    modport slave (
        output delay, in_valid, in_data, out_ready, ram_dataOut,
        input  in_ready, out_valid, out_data, ram_wEn, ram_addr, ram_dataIn
    );

endinterface
`default_nettype wire

// File: rtl/sample_delay_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sample_delay_ctrl
// Brief    : Circular RAM delay line for the echo path (read old, write new).
// Revision : 1.0
// ============================================================================
module sample_delay_ctrl
    import sample_delay_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = SDC_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = SDC_ADDRESS_WIDTH,
    parameter int DEPTH         = SDC_DEPTH
) (
    input  logic                clk,
    input  logic                rst_n,
    sample_delay_ctrl_if.master bus
);

    localparam logic [ADDRESS_WIDTH-1:0] c_PTR_LAST = ADDRESS_WIDTH'(DEPTH - 1);

    sdc_state_t               r_state;
    // Clear counter during CLEAR, write pointer afterwards; CLEAR ends with it wrapped to 0
    logic [ADDRESS_WIDTH-1:0] r_ptr;
    logic [ADDRESS_WIDTH-1:0] r_dly;
    logic [DATA_WIDTH-1:0]    r_smp;
    logic                     r_out_valid;
    logic [DATA_WIDTH-1:0]    r_out_data;

    logic                     w_ram_wen;
    logic [ADDRESS_WIDTH-1:0] w_ram_addr;
    logic [DATA_WIDTH-1:0]    w_ram_din;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_CLEAR;
            r_ptr       <= '0;
            r_dly       <= '0;
            r_smp       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_ptr <= r_ptr + 1'b1;
                    if (r_ptr == c_PTR_LAST) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_smp   <= bus.in_data;
                        r_dly   <= bus.delay;
                        r_state <= ST_READ;
                    end
                end
                ST_READ: begin
                    r_state <= ST_WRITE;
                end
                ST_WRITE: begin
                    // RAM holds its READ-phase output because wEn is high this cycle
                    r_out_data  <= (r_dly == '0) ? r_smp : bus.ram_dataOut;
                    r_out_valid <= 1'b1;
                    r_ptr       <= r_ptr + 1'b1;
                    r_state     <= ST_OUT;
                end
                ST_OUT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_CLEAR;
                    r_ptr   <= '0;
                end
            endcase
        end
    end

    // RAM port decoded from registers only so it is settled by the negedge
    always_comb begin
        w_ram_wen  = 1'b0;
        w_ram_addr = r_ptr;
        w_ram_din  = '0;
        case (r_state)
            ST_CLEAR: w_ram_wen = 1'b1;
            ST_READ:  w_ram_addr = r_ptr - r_dly;
            ST_WRITE: begin
                w_ram_wen = 1'b1;
                w_ram_din = r_smp;
            end
            default: ;
        endcase
    end

    assign bus.ram_wEn    = w_ram_wen;
    assign bus.ram_addr   = w_ram_addr;
    assign bus.ram_dataIn = w_ram_din;
    assign bus.in_ready   = (r_state == ST_IDLE);
    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_sample_delay_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sample_delay_ctrl
// Brief    : Directed bench for the echo delay line with a negedge RAM model.
// Revision : 1.0
// ============================================================================
module tb_sample_delay_ctrl;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int DP = 16;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    int   cyc;
    int   acc_cyc;

    logic [DW-1:0] mem [DP];

    sample_delay_ctrl_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

    sample_delay_ctrl #(
        .DATA_WIDTH    (DW),
        .ADDRESS_WIDTH (AW),
        .DEPTH         (DP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.ram_wEn) mem[bus.ram_addr] <= bus.ram_dataIn;
        else             bus.ram_dataOut   <= mem[bus.ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Pre-fills the RAM with junk, pulses reset and waits out CLEAR
    task automatic do_reset(input string tag);
        int n;
        rst_n = 1'b0;
        for (int i = 0; i < DP; i++) mem[i] = 32'hDEAD_0000 + 32'(i);
        tick();
        tick();
        chk({tag, "_rst_rdy"},  32'(bus.in_ready),  32'd0);
        chk({tag, "_rst_ov"},   32'(bus.out_valid), 32'd0);
        chk({tag, "_rst_wen"},  32'(bus.ram_wEn),   32'd1);
        chk({tag, "_rst_addr"}, 32'(bus.ram_addr),  32'd0);
        rst_n = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_clr_len"}, 32'(n), 32'd16);
    endtask

    // Accepts one sample, checks 3-cycle latency and the delayed value
    task automatic push(input string tag, input logic [DW-1:0] d,
                        input logic [AW-1:0] dl, input logic [DW-1:0] exp);
        int n;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.delay    = dl;
        acc_cyc      = cyc;
        tick();
        bus.in_valid = 1'b0;
        bus.delay    = ~dl;
        n = 1;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'd3);
        chk(tag, bus.out_data, exp);
        if (bus.out_ready) tick();
    endtask

    initial begin
        int prev;
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        acc_cyc = 0;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.delay     = '0;
        bus.out_ready = 1'b1;

        // 1: CLEAR length and zeroed history
        do_reset("t1");
        for (int i = 0; i < DP; i++) chk($sformatf("t1_mem%0d", i), mem[i], 32'd0);

        // 2: delay 3, one sample every 4 cycles
        prev = 0;
        for (int k = 1; k <= 8; k++) begin
            push($sformatf("t2_out%0d", k), 32'(k), 4'd3, (k <= 3) ? 32'd0 : 32'(k - 3));
            if (k > 1) chk($sformatf("t2_per%0d", k), 32'(acc_cyc - prev), 32'd4);
            prev = acc_cyc;
        end

        // 3: delay 0 bypass still writes the RAM
        do_reset("t3");
        push("t3_out5", 32'd5, 4'd0, 32'd5);
        push("t3_out6", 32'd6, 4'd0, 32'd6);
        push("t3_out7", 32'd7, 4'd0, 32'd7);
        chk("t3_mem0", mem[0], 32'd5);
        chk("t3_mem1", mem[1], 32'd6);
        chk("t3_mem2", mem[2], 32'd7);

        // 4: maximum delay across two pointer wraps
        do_reset("t4");
        for (int k = 1; k <= 40; k++)
            push($sformatf("t4_out%0d", k), 32'(k), 4'd15, (k >= 16) ? 32'(k - 15) : 32'd0);

        // 5: backpressure in OUT, with a pending source sample ignored
        bus.out_ready = 1'b0;
        push("t5_out41", 32'd41, 4'd15, 32'd26);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hBAD;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("t5_ov%0d", i),  32'(bus.out_valid), 32'd1);
            chk($sformatf("t5_od%0d", i),  bus.out_data,       32'd26);
            chk($sformatf("t5_rdy%0d", i), 32'(bus.in_ready),  32'd0);
            chk($sformatf("t5_wen%0d", i), 32'(bus.ram_wEn),   32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("t5_ov_drop", 32'(bus.out_valid), 32'd0);
        push("t5_out42", 32'd42, 4'd15, 32'd27);

        // 6: asynchronous reset from OUT and from WRITE
        bus.out_ready = 1'b0;
        push("t6_pre", 32'd43, 4'd15, 32'd28);
        rst_n = 1'b0;
        #1;
        chk("t6_ov_async", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b1;
        do_reset("t6a");
        bus.in_valid = 1'b1;
        bus.in_data  = 32'd99;
        bus.delay    = 4'd2;
        tick();
        bus.in_valid = 1'b0;
        tick();
        chk("t6_in_write", 32'(bus.ram_wEn), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_ov_wr",   32'(bus.out_valid), 32'd0);
        chk("t6_addr_wr", 32'(bus.ram_addr),  32'd0);
        do_reset("t6b");
        push("t6_out11", 32'd11, 4'd2, 32'd0);
        push("t6_out12", 32'd12, 4'd2, 32'd0);
        push("t6_out13", 32'd13, 4'd2, 32'd11);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
